// File: rtl/pe_context_sequencer.sv
// pe_context_sequencer: steps NUM_CTX config words modulo ii for num_iter iterations, feeding the PE ALU
module pe_context_sequencer #(
  parameter int NUM_CTX = 16,
  parameter int CTX_AW = 4,
  parameter int CFG_W = 48,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CTX_AW-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              start,
  input  logic [CTX_AW:0]   ii,
  input  logic [ITER_W-1:0] num_iter,
  input  logic              stall,
  input  logic              abort,
  output logic [5:0]        alu_operation,
  output logic [1:0]        rhs_sel,
  output logic [1:0]        lhs_sel,
  output logic              res_we,
  output logic [31:0]       const_out,
  output logic [CTX_AW-1:0] ctx_ptr,
  output logic              issue_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CFG_W-1:0] mem [NUM_CTX];
  logic [CFG_W-1:0] word;
  logic [CTX_AW-1:0] ptr;
  logic [ITER_W-1:0] iter, num_iter_l;
  logic [CTX_AW:0] ii_l;
  logic addr_ok, start_ok, go, adv, clr, last_slot, last_iter, err_n, unused_rsvd;
  assign word = mem[ptr];
  assign unused_rsvd = ^word[15:11];
  assign addr_ok = {1'b0, cfg_addr} < (CTX_AW+1)'(NUM_CTX);
  assign start_ok = ii != '0 && ii <= (CTX_AW+1)'(NUM_CTX) && num_iter != '0;
  assign go = state == IDLE && start && start_ok;
  assign adv = state == RUN && !abort && !stall;
  assign clr = state != IDLE && abort;
  assign last_slot = {1'b0, ptr} == ii_l - (CTX_AW+1)'(1);
  assign last_iter = iter == num_iter_l - ITER_W'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    state_n = state == IDLE ? (go ? RUN : IDLE) :
              state == RUN  ? (abort ? IDLE : adv && last_slot && last_iter ? DONE : RUN) : IDLE;
    err_n = state == IDLE ? (cfg_we && !addr_ok) || (start && !start_ok) : cfg_we;
  end
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE && addr_ok)
      mem[cfg_addr] <= cfg_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      iter <= '0;
      ii_l <= '0;
      num_iter_l <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= err_n;
      if (go) begin
        ii_l <= ii;
        num_iter_l <= num_iter;
        ptr <= '0;
        iter <= '0;
      end else if (adv) begin
        ptr <= last_slot ? '0 : ptr + 1'b1;
        if (last_slot && !last_iter)
          iter <= iter + 1'b1;
      end
    end
  end
  // a stalled or finishing cycle shows a nop but keeps the operand selects of the last issue
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      alu_operation <= '0;
      rhs_sel <= '0;
      lhs_sel <= '0;
      res_we <= 1'b0;
      const_out <= '0;
      ctx_ptr <= '0;
      issue_valid <= 1'b0;
    end else if (adv) begin
      alu_operation <= word[5:0];
      rhs_sel <= word[7:6];
      lhs_sel <= word[9:8];
      res_we <= word[10];
      const_out <= word[47:16];
      ctx_ptr <= ptr;
      issue_valid <= 1'b1;
    end else if (state != IDLE) begin
      alu_operation <= '0;
      issue_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pe_context_sequencer.sv
// tb_pe_context_sequencer: directed runs checked every cycle against an issue-count model plus literal expectations
module tb_pe_context_sequencer;
  logic clk = 1'b0;
  logic reset, cfg_we, start, stall, abort;
  logic [3:0] cfg_addr;
  logic [47:0] cfg_data;
  logic [4:0] ii;
  logic [15:0] num_iter;
  logic [5:0] alu_operation;
  logic [1:0] rhs_sel, lhs_sel;
  logic res_we, issue_valid, busy, done, cfg_err;
  logic [31:0] const_out;
  logic [3:0] ctx_ptr;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [5:0] ops [3];
  logic [47:0] m_mem [16];
  logic [47:0] m_out;
  logic [3:0] m_ptr;
  logic m_valid, m_busy, m_done, m_err;
  int m_k, m_ii, m_tot;
  logic [50:0] got, exp_v;

  pe_context_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .ii(ii), .num_iter(num_iter), .stall(stall), .abort(abort),
    .alu_operation(alu_operation), .rhs_sel(rhs_sel), .lhs_sel(lhs_sel), .res_we(res_we),
    .const_out(const_out), .ctx_ptr(ctx_ptr), .issue_valid(issue_valid), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // model: a run is ii*num_iter issues, issue k presents slot k mod ii
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_out <= '0;
      m_ptr <= '0;
      m_valid <= 1'b0;
      m_err <= 1'b0;
      m_k <= 0;
    end else begin
      m_err <= m_busy ? cfg_we : (cfg_we && int'(cfg_addr) >= 16) ||
               (start && !(ii >= 1 && ii <= 16 && num_iter != 0));
      if (m_busy && abort) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
        m_out <= '0;
        m_ptr <= '0;
        m_valid <= 1'b0;
      end else if (m_done) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
        m_valid <= 1'b0;
        m_out[5:0] <= '0;
      end else if (m_busy) begin
        if (stall) begin
          m_valid <= 1'b0;
          m_out[5:0] <= '0;
        end else begin
          m_out <= m_mem[m_k % m_ii];
          m_ptr <= 4'(m_k % m_ii);
          m_valid <= 1'b1;
          m_k <= m_k + 1;
          if (m_k + 1 == m_tot) m_done <= 1'b1;
        end
      end else begin
        if (cfg_we && int'(cfg_addr) < 16) m_mem[cfg_addr] <= cfg_data;
        if (start && ii >= 1 && ii <= 16 && num_iter != 0) begin
          m_busy <= 1'b1;
          m_k <= 0;
          m_ii <= int'(ii);
          m_tot <= int'(ii) * int'(num_iter);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      got = {alu_operation, rhs_sel, lhs_sel, res_we, const_out, ctx_ptr, issue_valid, busy, done, cfg_err};
      exp_v = {m_out[5:0], m_out[7:6], m_out[9:8], m_out[10], m_out[47:16], m_ptr, m_valid, m_busy, m_done, m_err};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got=%h expected=%h", $time, got, exp_v);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [47:0] g, input logic [47:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, g, e);
    end
  endtask

  task automatic wr(input int a, input logic [5:0] op, input logic [31:0] c);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = {c, 5'b0, 1'(a), 2'(a), 2'(a + 1), op};
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic run_start(input int i, input int n);
    start = 1'b1;
    ii = 5'(i);
    num_iter = 16'(n);
    tick;
    start = 1'b0;
  endtask

  int bi [3];
  int bn [3];

  initial begin
    ops[0] = 6'h01; ops[1] = 6'h02; ops[2] = 6'h0B;
    bi[0] = 0; bi[1] = 17; bi[2] = 3;
    bn[0] = 2; bn[1] = 2; bn[2] = 0;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; ii = '0; num_iter = '0; stall = 1'b0; abort = 1'b0;
    repeat (3) tick;
    chk("rst_valid", issue_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op", alu_operation, 0);
    chk("rst_const", const_out, 0);
    chk_en = 1'b1;
    reset = 1'b0;
    wr(0, 6'h01, 5);
    wr(1, 6'h02, 6);
    wr(2, 6'h0B, 7);
    // basic 3-slot, 2-iteration run
    run_start(3, 2);
    chk("t1_busy", busy, 1);
    chk("t1_first_gap", issue_valid, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t1_op", alu_operation, ops[i % 3]);
      chk("t1_ptr", ctx_ptr, i % 3);
      chk("t1_const", const_out, 5 + i % 3);
      chk("t1_valid", issue_valid, 1);
      chk("t1_done", done, i == 5);
    end
    tick;
    chk("t1_idle", busy, 0);
    chk("t1_after_valid", issue_valid, 0);
    // two stall cycles during the second issue
    run_start(3, 2);
    tick;
    chk("t2_slot0", alu_operation, 6'h01);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("t2_gap_valid", issue_valid, 0);
      chk("t2_gap_op", alu_operation, 0);
      chk("t2_gap_hold", const_out, 5);
    end
    stall = 1'b0;
    for (int i = 1; i < 6; i++) begin
      tick;
      chk("t2_op", alu_operation, ops[i % 3]);
      chk("t2_ptr", ctx_ptr, i % 3);
      chk("t2_done", done, i == 5);
    end
    tick;
    chk("t2_idle", busy, 0);
    // ii == 1
    wr(0, 6'h1F, 9);
    run_start(1, 4);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t3_op", alu_operation, 6'h1F);
      chk("t3_ptr", ctx_ptr, 0);
      chk("t3_done", done, i == 3);
    end
    tick;
    chk("t3_idle", busy, 0);
    wr(0, 6'h01, 5);
    // rejected starts
    for (int i = 0; i < 3; i++) begin
      run_start(bi[i], bn[i]);
      chk("t4_err", cfg_err, 1);
      chk("t4_busy", busy, 0);
      tick;
      chk("t4_err_clr", cfg_err, 0);
      chk("t4_valid", issue_valid, 0);
      chk("t4_done", done, 0);
    end
    // ii == NUM_CTX uses every slot
    for (int i = 3; i < 16; i++) wr(i, 6'(i + 16), 32'(i * 3));
    run_start(16, 1);
    for (int i = 0; i < 16; i++) tick;
    chk("t4b_done", done, 1);
    chk("t4b_ptr", ctx_ptr, 15);
    chk("t4b_op", alu_operation, 6'h1F);
    tick;
    chk("t4b_idle", busy, 0);
    // write during run is dropped; abort on third issue
    run_start(3, 2);
    cfg_we = 1'b1;
    cfg_addr = 4'd1;
    cfg_data = {32'd99, 10'b0, 6'h0D};
    tick;
    cfg_we = 1'b0;
    chk("t5_werr", cfg_err, 1);
    tick;
    tick;
    chk("t5_third", alu_operation, 6'h0B);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", issue_valid, 0);
    chk("t5_op", alu_operation, 0);
    chk("t5_const", const_out, 0);
    chk("t5_nodone", done, 0);
    run_start(3, 2);
    tick;
    tick;
    chk("t5_slot1_kept", alu_operation, 6'h02);
    chk("t5_slot1_const", const_out, 6);
    repeat (5) tick;
    chk("t5_idle", busy, 0);
    // reset while stalled mid-run
    run_start(3, 2);
    tick;
    tick;
    stall = 1'b1;
    reset = 1'b1;
    tick;
    chk("t6_busy", busy, 0);
    chk("t6_valid", issue_valid, 0);
    chk("t6_const", const_out, 0);
    chk("t6_ptr", ctx_ptr, 0);
    reset = 1'b0;
    stall = 1'b0;
    run_start(3, 2);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t6_op", alu_operation, ops[i % 3]);
      chk("t6_ptr_run", ctx_ptr, i % 3);
    end
    tick;
    chk("t6_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_context_sequencer.md
Name: pe_context_sequencer

Overview:
- Per-PE context sequencer that feeds the 6-bit operation code and operand-source selects to the PE's ALU each cycle.
- Holds NUM_CTX configuration words, written by the host/config loader while idle.
- When started, steps a context pointer modulo the initiation interval (ii) for num_iter iterations, then signals done.
- Sits between the config bus and the PE datapath (ALU plus operand muxes).

Parameters:
- NUM_CTX, 16, number of configuration words (context slots).
- CTX_AW, 4, context address width, equal to log2(NUM_CTX).
- CFG_W, 48, config word width. Fields: [5:0] operation, [7:6] rhs_sel, [9:8] lhs_sel, [10] res_we, [15:11] reserved, [47:16] const.
- ITER_W, 16, iteration counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- cfg_we  input  1  config word write strobe.
- cfg_addr  input  CTX_AW  config write slot.
- cfg_data  input  CFG_W  config write data.
- start  input  1  begin run; sampled only in IDLE.
- ii  input  CTX_AW+1  initiation interval in slots; valid range 1..NUM_CTX; sampled on start.
- num_iter  input  ITER_W  iteration count; sampled on start.
- stall  input  1  freeze sequencing.
- abort  input  1  terminate run.
- alu_operation  output  6  operation code to the ALU.
- rhs_sel  output  2  RHS operand source select.
- lhs_sel  output  2  LHS operand source select.
- res_we  output  1  result register write enable.
- const_out  output  32  immediate operand.
- ctx_ptr  output  CTX_AW  slot number of the currently presented outputs.
- issue_valid  output  1  outputs carry a real issue this cycle.
- busy  output  1  state is RUN or DONE.
- done  output  1  one-cycle completion pulse.
- cfg_err  output  1  one-cycle pulse for a rejected write or start.

Behaviour:
- Reset:
  - state=IDLE; pointer, iteration counter and all outputs are 0 (alu_operation=6'b000000 is nop).
  - Config memory contents are not reset.
- States:
  - IDLE: cfg_we writes mem[cfg_addr] at the clock edge.
    - Write with cfg_addr >= NUM_CTX: dropped, cfg_err pulses.
    - start with ii in 1..NUM_CTX and num_iter != 0: latch ii and num_iter, ptr=0, iter=0, go to RUN.
    - start with ii==0, ii>NUM_CTX, or num_iter==0: stay IDLE, cfg_err pulses, no issue.
    - cfg_we and start in the same cycle: the write lands first, and the run uses the new word.
  - RUN, each cycle without stall:
    - All output registers load from mem[ptr]; ctx_ptr<=ptr; issue_valid<=1.
    - ptr<=(ptr==ii_l-1)?0:ptr+1.
    - On wrap, iter<=iter+1.
    - When ptr==ii_l-1 and iter==num_iter_l-1: go to DONE.
  - RUN with stall:
    - ptr and iter hold.
    - Next cycle: issue_valid=0 and alu_operation=0.
    - The other outputs hold their last values.
  - DONE:
    - Lasts exactly one cycle; done=1 while in DONE.
    - Outputs present the final slot with issue_valid=1.
    - Next cycle: IDLE, issue_valid=0, alu_operation=0.
    - stall is ignored in DONE.
- Latency:
  - First issue_valid appears 2 edges after start is sampled: one edge to enter RUN, one edge to register slot 0.
  - Total issue_valid cycles per run = ii_l*num_iter_l exactly; stall cycles are not counted.
- Config writes:
  - cfg_we during RUN or DONE is dropped and cfg_err pulses.
- abort:
  - In RUN or DONE, the next state is IDLE and outputs clear to 0.
  - No done pulse.
  - abort has priority over stall and over completion.
  - abort in IDLE is a no-op.
- Priority: reset > abort > stall > normal sequencing.
- Other rules:
  - start during RUN or DONE is ignored silently.
  - Counter arithmetic is unsigned.
  - iter never exceeds num_iter_l-1; ptr never exceeds ii_l-1.
  - Wrap with ii_l==1: ptr stays 0 and iter increments every cycle.

Test Plan:
1. Write slots 0..2 with ops 6'h01/6'h02/6'h0B and const 5/6/7, then start with ii=3, num_iter=2 -> issue_valid for 6 consecutive cycles starting at start+2. Ops sequence 01,02,0B,01,02,0B; ctx_ptr 0,1,2,0,1,2; done coincides with the 6th issue; busy drops the cycle after.
2. Same config; assert stall for 2 cycles during the 2nd issue -> exactly 2 gap cycles with issue_valid=0 and alu_operation=0. Sequence resumes at slot 1 with no slot skipped or repeated; still 6 issues total.
3. ii=1, num_iter=4, slot0 op=6'h1F -> 4 back-to-back issues of 6'h1F with ctx_ptr=0; done on the 4th.
4. start with ii=0, then with ii=17, then with num_iter=0 -> each produces a cfg_err pulse, stays IDLE, no issue_valid, no done.
5. During RUN, cfg_we to slot 1 with op 6'h0D; then abort on the 3rd issue -> write dropped with cfg_err; next cycle IDLE with outputs 0 and no done. A rerun shows slot 1 unchanged at op 6'h02.
6. Assert reset mid-RUN while stall=1 -> next cycle IDLE with all outputs 0. A following start runs correctly from slot 0 with the retained config.
